sigma_acc: RTL and testbench
============================

SIGMA_ACC -- requirements
Module: sigma_acc

Interface
REQ-001 The block SHALL have parameter N, default `N from config.svh, meaning the total signed-magnitude word width (bit N-1 is the sign).
REQ-002 The block SHALL have parameter F, default `F, meaning the number of fraction bits; F has no effect on arithmetic and only defines scaling.
REQ-003 The block SHALL have parameter LEN, default 4, legal range 2..1024, meaning the number of terms per sum.
REQ-004 The block SHALL have port clk, input, width 1: single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_data, input, width N: signed-magnitude term.
REQ-007 The block SHALL have port in_valid, input, width 1: in_data is valid this cycle.
REQ-008 The block SHALL have port in_last, input, width 1: marks the final term of a sum before LEN terms (early close).
REQ-009 The block SHALL have port in_ready, output, width 1: the block accepts a term this cycle.
REQ-010 The block SHALL have port out_data, output, width N: signed-magnitude sum.
REQ-011 The block SHALL have port out_valid, output, width 1: out_data and out_sat are valid.
REQ-012 The block SHALL have port out_ready, input, width 1: the consumer takes the result.
REQ-013 The block SHALL have port out_sat, output, width 1: the sum was clipped to full-scale magnitude.

Function
REQ-014 A term SHALL be accepted exactly when in_valid and in_ready are both high on a rising clock edge.
REQ-015 The FSM SHALL have two states, ACC and HOLD; in_ready SHALL be 1 in ACC and 0 in HOLD.
REQ-016 Each accepted term SHALL be converted from signed magnitude to two's complement and added into an internal accumulator.
- Accumulator width SHALL be ACC_W = N + clog2(LEN).
- The accumulator SHALL never wrap internally.
REQ-017 A term counter SHALL count accepted terms from 0.
- On acceptance with count == LEN-1, or with in_last = 1, the FSM SHALL go to HOLD.
- On that edge the counter SHALL clear and the final sum SHALL be registered into out_data and out_sat.
REQ-018 Latency: out_valid SHALL rise on the edge that accepts the closing term, i.e. it is visible in the cycle after that term is presented.
REQ-019 Output conversion SHALL map the two's-complement sum back to signed magnitude.
- If |sum| > 2^(N-1)-1, the magnitude SHALL be clipped to 2^(N-1)-1, the sign kept, and out_sat = 1; otherwise out_sat = 0.
REQ-020 A zero sum SHALL always be output as +0 (all bits 0); an input of -0 (0x8000 for N=16) SHALL be treated as 0.
REQ-021 In HOLD, out_data, out_sat and out_valid SHALL stay stable until out_ready = 1.
- On the edge where out_valid and out_ready are both high, the FSM SHALL return to ACC, out_valid SHALL drop, and the accumulator SHALL clear.
REQ-022 No term SHALL be accepted in the same cycle a result is drained; throughput is LEN+1 cycles per sum at full rate.
REQ-023 in_last asserted on the first term SHALL produce a one-term sum equal to that term (normalised per REQ-020).
REQ-024 in_data and in_last SHALL be ignored when in_valid = 0 or in_ready = 0.

Reset
REQ-025 When rst_n = 0, the block SHALL immediately and asynchronously set:
- state to ACC
- counter and accumulator to 0
- out_data to 0, out_valid to 0, out_sat to 0
- in_ready to 1 once rst_n is released.
REQ-026 A reset during ACC or HOLD SHALL discard the partial or pending sum; no out_valid pulse SHALL follow the reset.

Structure
REQ-027 The enum state_t {ACC, HOLD} and the function acc_w(N, LEN) SHALL reside in package sigma_pkg.
REQ-028 Signed-magnitude to/from two's-complement conversion, including saturation, SHALL be one sub-module, sm_conv, instantiated once at the input and once at the output.
REQ-029 Only the accumulator, counter, FSM and output registers SHALL be sequential; the block SHALL have no combinational path from out_ready to in_ready.

Verification (N=16, F=8, LEN=4)
REQ-030 Scenario: terms 0x0180, 0x0100, 0x8080, 0x0000 with in_valid held high -> after the 4th term, out_data = 0x0200 (2.0), out_sat = 0, out_valid high for one cycle with out_ready = 1.
REQ-031 Scenario: terms 0x7FFF x4 -> out_data = 0x7FFF, out_sat = 1; terms 0xFFFF x4 -> out_data = 0xFFFF, out_sat = 1.
REQ-032 Scenario: 0x0100 then 0x8100 with in_last on the 2nd term -> out_data = 0x0000 (not 0x8000), out_valid after 2 terms.
REQ-033 Scenario: out_ready held low 5 cycles after a result -> in_ready = 0 and out_data stable for all 5 cycles; the next sum starts only after the drain edge.
REQ-034 Scenario: rst_n pulsed low after 2 accepted terms -> outputs are 0 immediately; a following 4-term sum of 0x0100 gives 0x0400 with no residue from the earlier terms.
REQ-035 Scenario: random in_valid/out_ready over 1000 sums, LEN=3 -> every result matches the reference model, with no lost or duplicated terms.

Source files
------------

// File: rtl/sigma_pkg.sv
// Shared types and sizing helpers for the signed-magnitude accumulator.
// Word-format defaults; a build may predefine N and F to override them.
`ifndef N
`define N 16
`endif
`ifndef F
`define F 8
`endif

package sigma_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Headroom so LEN full-scale terms can never wrap the accumulator.
  function automatic int acc_w(input int n, input int len);
    return n + $clog2(len);
  endfunction

endpackage

// File: rtl/sm_conv.sv
// Signed-magnitude <-> two's-complement converter.
// TO_SM=0 widens an N-bit SM word to W bits; TO_SM=1 narrows a W-bit sum with clipping.
module sm_conv #(
  parameter int N     = 16,
  parameter int W     = 18,
  parameter bit TO_SM = 1'b0,
  parameter int IW    = TO_SM ? W : N,
  parameter int OW    = TO_SM ? N : W
) (
  input  logic [IW-1:0] din,
  output logic [OW-1:0] dout,
  output logic          sat
);

  if (TO_SM) begin : g_to_sm
    localparam logic [W-1:0] MAX_MAG = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
    logic [W-1:0]   mag_full;
    logic [N-2:0]   mag_clip;

    assign mag_full = din[W-1] ? (~din + 1'b1) : din;
    assign sat      = (mag_full > MAX_MAG);
    assign mag_clip = sat ? {(N-1){1'b1}} : mag_full[N-2:0];
    // A zero magnitude always leaves as +0, never -0.
    assign dout     = {din[W-1] & (|mag_clip), mag_clip};
  end else begin : g_to_tc
    logic [W-1:0] mag_ext;

    assign mag_ext = {{(W-N+1){1'b0}}, din[N-2:0]};
    assign dout    = din[N-1] ? (~mag_ext + 1'b1) : mag_ext;
    assign sat     = 1'b0;
  end

endmodule

// File: rtl/sigma_acc.sv
// Sums LEN (or fewer, on in_last) signed-magnitude terms and presents the clipped
// signed-magnitude result, holding it until the consumer drains it.
module sigma_acc
  import sigma_pkg::*;
#(
  parameter int N   = `N,
  parameter int F   = `F,
  parameter int LEN = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sat
);

  localparam int ACC_W = acc_w(N, LEN);
  localparam int CNT_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
  // F only fixes the binary point for users of the block.
  localparam int unused_f = F;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   term_tc;
  logic [ACC_W-1:0]   acc_next;
  logic [N-1:0]       sum_sm;
  logic               sum_sat;
  logic               unused_in_sat;
  logic               closing;

  sm_conv #(.N(N), .W(ACC_W), .TO_SM(1'b0)) u_in_conv (
    .din  (in_data),
    .dout (term_tc),
    .sat  (unused_in_sat)
  );

  assign acc_next = acc + term_tc;

  sm_conv #(.N(N), .W(ACC_W), .TO_SM(1'b1)) u_out_conv (
    .din  (acc_next),
    .dout (sum_sm),
    .sat  (sum_sat)
  );

  assign closing = (cnt == LAST_CNT) || in_last;

  // in_ready is a register mirroring state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            acc <= acc_next;
            if (closing) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              cnt       <= '0;
              out_data  <= sum_sm;
              out_sat   <= sum_sat;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
          end
        end
        default: begin
          state    <= ACC;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_acc.sv
// Scoreboard bench: directed scenarios on a LEN=4 instance, random traffic on LEN=3.
module tb_sigma_acc;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [15:0] a_in = 16'h0;
  logic        a_iv = 1'b0, a_il = 1'b0, a_or = 1'b1;
  logic [15:0] a_out;
  logic        a_ir, a_ov, a_os;

  logic [15:0] b_in = 16'h0;
  logic        b_iv = 1'b0, b_il = 1'b0, b_or = 1'b1;
  logic [15:0] b_out;
  logic        b_ir, b_ov, b_os;

  int   total = 0;
  int   bad = 0;
  res_t qa[$];
  res_t qb[$];
  res_t ra, rb;
  int   sum_a = 0, cnt_a = 0, sum_b = 0, cnt_b = 0, nb_seen = 0;

  sigma_acc #(.N(16), .F(8), .LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in), .in_valid(a_iv), .in_last(a_il),
    .in_ready(a_ir), .out_data(a_out), .out_valid(a_ov), .out_ready(a_or), .out_sat(a_os)
  );

  sigma_acc #(.N(16), .F(8), .LEN(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in), .in_valid(b_iv), .in_last(b_il),
    .in_ready(b_ir), .out_data(b_out), .out_valid(b_ov), .out_ready(b_or), .out_sat(b_os)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sm2int(input logic [15:0] t);
    return t[15] ? -int'(t[14:0]) : int'(t[14:0]);
  endfunction

  function automatic res_t close_sum(input int s);
    res_t r;
    int   m;
    m   = (s < 0) ? -s : s;
    r.s = (m > 32767);
    if (r.s) m = 32767;
    r.d = {((s < 0) && (m != 0)), m[14:0]};
    return r;
  endfunction

  // Monitors: a drain happens on the coming edge when out_valid and out_ready are both high.
  always @(negedge clk) begin
    #2;
    if (rst_n && a_ov && a_or) begin
      if (qa.size() == 0) chk_eq("a_extra", 32'(qa.size()), 1);
      else begin
        ra = qa.pop_front();
        chk_eq("a_data", a_out, ra.d);
        chk_eq("a_sat", a_os, ra.s);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && b_ov && b_or) begin
      nb_seen++;
      if (qb.size() == 0) chk_eq("b_extra", 32'(qb.size()), 1);
      else begin
        rb = qb.pop_front();
        chk_eq("b_data", b_out, rb.d);
        chk_eq("b_sat", b_os, rb.s);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the term is taken.
  task automatic send_a(input logic [15:0] d, input logic last, output int waits);
    waits = 0;
    a_in = d; a_il = last; a_iv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (a_ir) begin
        sum_a += sm2int(d);
        if (cnt_a == 3 || last) begin
          qa.push_back(close_sum(sum_a));
          sum_a = 0; cnt_a = 0;
        end else cnt_a++;
        @(negedge clk);
        return;
      end
      waits++;
      @(negedge clk);
    end
    chk_eq("a_timeout", waits, 0);
  endtask

  task automatic put_a(input logic [15:0] d, input logic last);
    int w;
    send_a(d, last, w);
  endtask

  task automatic result_a(input string tag, input logic [15:0] d, input logic s);
    a_iv = 1'b0; a_il = 1'b0;
    #1;
    chk_eq({tag, "_valid"}, a_ov, 1);
    chk_eq({tag, "_data"}, a_out, d);
    chk_eq({tag, "_sat"}, a_os, s);
    @(negedge clk);
  endtask

  initial begin
    int w, closed, cyc;
    logic [15:0] t;
    logic cl;

    repeat (2) @(negedge clk);
    #1;
    chk_eq("rst_ov", a_ov, 0);
    chk_eq("rst_out", a_out, 0);
    chk_eq("rst_sat", a_os, 0);
    chk_eq("rst_b_ov", b_ov, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("rst_ready", a_ir, 1);
    @(negedge clk);

    put_a(16'h0180, 0); put_a(16'h0100, 0); put_a(16'h8080, 0); put_a(16'h0000, 0);
    result_a("s1", 16'h0200, 0);
    #1;
    chk_eq("s1_drop", a_ov, 0);
    @(negedge clk);

    repeat (4) put_a(16'h7FFF, 0);
    result_a("pos_sat", 16'h7FFF, 1);
    put_a(16'hFFFF, 0);
    a_iv = 1'b0; a_il = 1'b1; a_in = 16'h0001;
    @(negedge clk);
    repeat (3) put_a(16'hFFFF, 0);
    result_a("neg_sat", 16'hFFFF, 1);

    put_a(16'h0100, 0); put_a(16'h8100, 1);
    result_a("zero", 16'h0000, 0);
    put_a(16'h8005, 1);
    result_a("one_term", 16'h8005, 0);
    put_a(16'h8000, 0); put_a(16'h0003, 0); put_a(16'h8000, 0); put_a(16'h0000, 0);
    result_a("negzero", 16'h0003, 0);
    put_a(16'h8000, 1);
    result_a("negzero1", 16'h0000, 0);

    a_or = 1'b0;
    repeat (4) put_a(16'h0100, 0);
    a_iv = 1'b1; a_il = 1'b1; a_in = 16'h7FFF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_eq("hold_ready", a_ir, 0);
      chk_eq("hold_data", a_out, 16'h0400);
      chk_eq("hold_valid", a_ov, 1);
      @(negedge clk);
    end
    a_or = 1'b1;
    send_a(16'h0100, 0, w);
    chk_eq("drain_block", w, 1);
    repeat (3) put_a(16'h0100, 0);
    result_a("after_hold", 16'h0400, 0);

    put_a(16'h0300, 0); put_a(16'h0300, 0);
    a_iv = 1'b0;
    #3;
    rst_n = 1'b0;
    sum_a = 0; cnt_a = 0; qa.delete();
    #1;
    chk_eq("mid_rst_out", a_out, 0);
    chk_eq("mid_rst_ov", a_ov, 0);
    chk_eq("mid_rst_sat", a_os, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("mid_rst_ready", a_ir, 1);
    @(negedge clk);
    repeat (4) put_a(16'h0100, 0);
    result_a("post_rst", 16'h0400, 0);

    closed = 0; cyc = 0;
    while (closed < 1000 && cyc < 40000) begin
      b_iv = ($urandom_range(0, 3) != 0);
      b_or = ($urandom_range(0, 1) == 1);
      b_il = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 7))
        0: t = 16'h7FFF;
        1: t = 16'hFFFF;
        2: t = 16'h8000;
        3: t = 16'h0000;
        default: t = 16'($urandom);
      endcase
      b_in = t;
      #1;
      if (b_iv && b_ir) begin
        sum_b += sm2int(t);
        cl = (cnt_b == 2) || b_il;
        if (cl) begin
          qb.push_back(close_sum(sum_b));
          sum_b = 0; cnt_b = 0; closed++;
        end else cnt_b++;
      end
      @(negedge clk);
      cyc++;
    end
    chk_eq("b_timeout", closed, 1000);
    b_iv = 1'b0; b_or = 1'b1;
    repeat (4) @(negedge clk);
    chk_eq("b_lost", 32'(qb.size()), 0);
    chk_eq("b_count", nb_seen, 1000);
    chk_eq("a_lost", 32'(qa.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
